vending_ctrl_param: RTL and testbench

//  Parametrised synchronous vending-machine controller: N products, per-product stock, quantity entry,

---
 rtl/vend_pkg.sv | 31 +++
 rtl/vend_stock_bank.sv | 46 ++++
 rtl/vending_ctrl_param.sv | 187 ++++++++++++++++++
 tb/tb_vending_ctrl_param.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types and helpers for the vending controller: FSM state encoding,
// coin codes, coin value lookup and bulk-discount arithmetic.
package vend_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_SELECT   = 2'b01,
        ST_PAY      = 2'b10,
        ST_DISPENSE = 2'b11
    } vend_state_e;

    localparam logic [1:0] COIN_500  = 2'b00;
    localparam logic [1:0] COIN_1000 = 2'b01;
    localparam logic [1:0] COIN_2000 = 2'b10;
    localparam logic [1:0] COIN_5000 = 2'b11;

    // Coin value in 500-units.
    function automatic logic [3:0] coin_value(input logic [1:0] c);
        case (c)
            COIN_500:  return 4'd1;
            COIN_1000: return 4'd2;
            COIN_2000: return 4'd4;
            default:   return 4'd10;
        endcase
    endfunction

    function automatic logic [31:0] disc(input logic [31:0] total, input logic apply);
        return apply ? (total - (total / 32'd10)) : total;
    endfunction

endpackage

// File: rtl/vend_stock_bank.sv
// Per-product stock counters with restock-to-full, decrement by dispensed
// quantity, and low-stock flags.
module vend_stock_bank
    import vend_pkg::*;
#(
    parameter int N_PROD   = 8,
    parameter int STOCK_W  = 4,
    parameter int QTY_W    = 4,
    parameter int WARN_LVL = 5,
    parameter int SEL_W    = $clog2(N_PROD)
) (
    input  logic                              clock,
    input  logic                              CLR,
    input  logic                              load_i,
    input  logic [SEL_W-1:0]                  load_idx_i,
    input  logic                              dec_i,
    input  logic [SEL_W-1:0]                  dec_idx_i,
    input  logic [QTY_W-1:0]                  dec_amt_i,
    output logic [N_PROD-1:0][STOCK_W-1:0]    stock_o,
    output logic [N_PROD-1:0]                 warn_o
);

    logic [N_PROD-1:0][STOCK_W-1:0] stock_q;

    // Load and decrement never coincide: restock is IDLE-only, decrement is DISPENSE-only.
    always_ff @(posedge clock) begin
        if (CLR) begin
            for (int i = 0; i < N_PROD; i++) stock_q[i] <= '1;
        end else begin
            for (int i = 0; i < N_PROD; i++) begin
                if (load_i && (32'(load_idx_i) == i))
                    stock_q[i] <= '1;
                else if (dec_i && (32'(dec_idx_i) == i))
                    stock_q[i] <= stock_q[i] - STOCK_W'(dec_amt_i);
            end
        end
    end

    always_comb begin
        warn_o = '0;
        for (int i = 0; i < N_PROD; i++) warn_o[i] = (32'(stock_q[i]) < WARN_LVL);
    end

    assign stock_o = stock_q;

endmodule

// File: rtl/vending_ctrl_param.sv
// Vending controller top: order FSM, quantity counter, coin accumulator and
// registered dispense/change/error strobes around the stock bank.
module vending_ctrl_param
    import vend_pkg::*;
#(
    parameter int N_PROD   = 8,
    parameter int PRICE_W  = 8,
    parameter int QTY_W    = 4,
    parameter int STOCK_W  = 4,
    parameter int WARN_LVL = 5,
    parameter int DISC_QTY = 10,
    parameter int TOT_W    = 12,
    parameter int SEL_W    = $clog2(N_PROD)
) (
    input  logic                        clock,
    input  logic                        CLR,
    input  logic [SEL_W-1:0]            key,
    input  logic                        key_valid,
    input  logic                        add_prod,
    input  logic                        confirm,
    input  logic [1:0]                  coin,
    input  logic                        coin_valid,
    input  logic                        cancel,
    input  logic                        restock,
    input  logic [N_PROD*PRICE_W-1:0]   price_tbl,
    output logic [N_PROD-1:0]           release_prod,
    output logic [QTY_W-1:0]            release_qty,
    output logic [TOT_W-1:0]            change_units,
    output logic                        change_valid,
    output logic                        order_err,
    output logic [N_PROD-1:0]           warn_sig,
    output logic [TOT_W-1:0]            pay_due,
    output logic [1:0]                  state_o
);

    vend_state_e                 state_q, state_d;
    logic [SEL_W-1:0]            sel_q, sel_d;
    logic [QTY_W-1:0]            qty_q, qty_d;
    logic [TOT_W-1:0]            acc_q, acc_d;
    logic [TOT_W-1:0]            due_q, due_d;
    logic [TOT_W-1:0]            pay_due_q, pay_due_d;
    logic [N_PROD-1:0]           release_prod_q, release_prod_d;
    logic [QTY_W-1:0]            release_qty_q, release_qty_d;
    logic [TOT_W-1:0]            change_units_q, change_units_d;
    logic                        change_valid_q, change_valid_d;
    logic                        order_err_q, order_err_d;
    logic                        restock_en, dec_en;
    logic [N_PROD-1:0][STOCK_W-1:0] stock;
    logic [PRICE_W-1:0]          price;
    logic [TOT_W-1:0]            total, total_disc;
    logic [TOT_W:0]              acc_sum;
    logic [TOT_W-1:0]            acc_sat;
    logic                        key_ok;

    vend_stock_bank #(
        .N_PROD(N_PROD), .STOCK_W(STOCK_W), .QTY_W(QTY_W), .WARN_LVL(WARN_LVL), .SEL_W(SEL_W)
    ) u_stock (
        .clock(clock), .CLR(CLR),
        .load_i(restock_en), .load_idx_i(key),
        .dec_i(dec_en), .dec_idx_i(sel_q), .dec_amt_i(qty_q),
        .stock_o(stock), .warn_o(warn_sig)
    );

    assign key_ok     = (32'(key) < N_PROD);
    assign price      = price_tbl[sel_q*PRICE_W +: PRICE_W];
    assign total      = TOT_W'(price) * TOT_W'(qty_q);
    assign total_disc = TOT_W'(disc(32'(total), 32'(qty_q) >= DISC_QTY));
    assign acc_sum    = {1'b0, acc_q} + (TOT_W+1)'(coin_value(coin));
    assign acc_sat    = acc_sum[TOT_W] ? '1 : acc_sum[TOT_W-1:0];

    // Cancel has priority over every other action in SELECT and PAY; the coin of
    // the cancel cycle is dropped. The coin of the cycle that enters DISPENSE counts.
    always_comb begin
        state_d        = state_q;
        sel_d          = sel_q;
        qty_d          = qty_q;
        acc_d          = acc_q;
        due_d          = due_q;
        pay_due_d      = pay_due_q;
        release_prod_d = '0;
        release_qty_d  = '0;
        change_units_d = '0;
        change_valid_d = 1'b0;
        order_err_d    = 1'b0;
        restock_en     = 1'b0;
        dec_en         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                pay_due_d  = '0;
                restock_en = restock && key_ok;
                if (key_valid) begin
                    if (key_ok && (stock[key] != '0)) begin
                        sel_d   = key;
                        qty_d   = QTY_W'(1);
                        state_d = ST_SELECT;
                    end else begin
                        order_err_d = 1'b1;
                    end
                end
            end
            ST_SELECT: begin
                if (cancel) begin
                    state_d        = ST_IDLE;
                    qty_d          = '0;
                    change_units_d = acc_q;
                    change_valid_d = (acc_q != '0);
                    acc_d          = '0;
                end else if (confirm) begin
                    if (32'(qty_q) <= 32'(stock[sel_q])) begin
                        due_d     = total_disc;
                        pay_due_d = total_disc;
                        state_d   = ST_PAY;
                    end else begin
                        order_err_d = 1'b1;
                    end
                end else if (add_prod && (qty_q != '1)) begin
                    qty_d = qty_q + 1'b1;
                end
            end
            ST_PAY: begin
                if (cancel) begin
                    state_d        = ST_IDLE;
                    qty_d          = '0;
                    acc_d          = '0;
                    pay_due_d      = '0;
                    change_units_d = acc_q;
                    change_valid_d = (acc_q != '0);
                end else begin
                    if (coin_valid) acc_d = acc_sat;
                    if (acc_q >= due_q) begin
                        state_d        = ST_DISPENSE;
                        pay_due_d      = '0;
                        release_prod_d = N_PROD'(1) << sel_q;
                        release_qty_d  = qty_q;
                        change_units_d = acc_d - due_q;
                        change_valid_d = (acc_d > due_q);
                    end
                end
            end
            ST_DISPENSE: begin
                dec_en  = 1'b1;
                acc_d   = '0;
                qty_d   = '0;
                due_d   = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (CLR) begin
            state_q        <= ST_IDLE;
            sel_q          <= '0;
            qty_q          <= '0;
            acc_q          <= '0;
            due_q          <= '0;
            pay_due_q      <= '0;
            release_prod_q <= '0;
            release_qty_q  <= '0;
            change_units_q <= '0;
            change_valid_q <= 1'b0;
            order_err_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            sel_q          <= sel_d;
            qty_q          <= qty_d;
            acc_q          <= acc_d;
            due_q          <= due_d;
            pay_due_q      <= pay_due_d;
            release_prod_q <= release_prod_d;
            release_qty_q  <= release_qty_d;
            change_units_q <= change_units_d;
            change_valid_q <= change_valid_d;
            order_err_q    <= order_err_d;
        end
    end

    assign release_prod = release_prod_q;
    assign release_qty  = release_qty_q;
    assign change_units = change_units_q;
    assign change_valid = change_valid_q;
    assign order_err    = order_err_q;
    assign pay_due      = pay_due_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_vending_ctrl_param.sv
// Directed self-checking bench for vending_ctrl_param: purchases, bulk discount,
// cancel/refund, stock warnings, order errors and mid-order reset.
module tb_vending_ctrl_param;

    logic        clock = 1'b0;
    logic        CLR;
    logic [2:0]  key;
    logic        key_valid, add_prod, confirm, coin_valid, cancel, restock;
    logic [1:0]  coin;
    logic [63:0] price_tbl;
    logic [7:0]  release_prod;
    logic [3:0]  release_qty;
    logic [11:0] change_units;
    logic        change_valid, order_err;
    logic [7:0]  warn_sig;
    logic [11:0] pay_due;
    logic [1:0]  state_o;

    int nVectors = 0;
    int nMiscompares = 0;

    always #5 clock = ~clock;

    vending_ctrl_param dut (
        .clock(clock), .CLR(CLR), .key(key), .key_valid(key_valid), .add_prod(add_prod),
        .confirm(confirm), .coin(coin), .coin_valid(coin_valid), .cancel(cancel),
        .restock(restock), .price_tbl(price_tbl), .release_prod(release_prod),
        .release_qty(release_qty), .change_units(change_units), .change_valid(change_valid),
        .order_err(order_err), .warn_sig(warn_sig), .pay_due(pay_due), .state_o(state_o)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        CLR = 1'b1;
        tick();
        tick();
        CLR = 1'b0;
        nVectors++;
        if (state_o !== 2'b00) begin nMiscompares++; $display("[TB] FAIL reset_state got %0h want 0", state_o); end
        nVectors++;
        if (warn_sig !== 8'h00) begin nMiscompares++; $display("[TB] FAIL reset_warn got %0h want 0", warn_sig); end
        nVectors++;
        if ({release_prod, release_qty, change_units, change_valid, order_err, pay_due} !== '0) begin
            nMiscompares++;
            $display("[TB] FAIL reset_outputs got rel=%0h qty=%0h chg=%0h cv=%0b err=%0b due=%0h want all 0",
                     release_prod, release_qty, change_units, change_valid, order_err, pay_due);
        end
    endtask

    task automatic test_single_buy();
        key = 3'd6; key_valid = 1'b1; tick(); key_valid = 1'b0;
        nVectors++;
        if (state_o !== 2'b01) begin nMiscompares++; $display("[TB] FAIL buy_select got %0h want 1", state_o); end
        confirm = 1'b1; tick(); confirm = 1'b0;
        nVectors++;
        if (state_o !== 2'b10 || pay_due !== 12'd3) begin
            nMiscompares++; $display("[TB] FAIL buy_pay got st=%0h due=%0d want st=2 due=3", state_o, pay_due);
        end
        coin = 2'b01; coin_valid = 1'b1; tick(); tick(); coin_valid = 1'b0;
        tick();
        nVectors++;
        if (state_o !== 2'b11 || release_prod !== 8'h40 || release_qty !== 4'd1 ||
            change_units !== 12'd1 || change_valid !== 1'b1 || pay_due !== 12'd0) begin
            nMiscompares++;
            $display("[TB] FAIL buy_dispense got st=%0h rel=%0h qty=%0d chg=%0d cv=%0b due=%0d want 3 40 1 1 1 0",
                     state_o, release_prod, release_qty, change_units, change_valid, pay_due);
        end
        tick();
        nVectors++;
        if (state_o !== 2'b00 || release_prod !== 8'h00 || change_valid !== 1'b0) begin
            nMiscompares++;
            $display("[TB] FAIL buy_idle got st=%0h rel=%0h cv=%0b want 0 0 0", state_o, release_prod, change_valid);
        end
    endtask

    task automatic test_discount();
        key = 3'd2; key_valid = 1'b1; tick(); key_valid = 1'b0;
        add_prod = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        add_prod = 1'b0;
        confirm = 1'b1; tick(); confirm = 1'b0;
        nVectors++;
        if (pay_due !== 12'd18) begin nMiscompares++; $display("[TB] FAIL disc_due got %0d want 18", pay_due); end
        coin = 2'b11; coin_valid = 1'b1; tick(); tick(); coin_valid = 1'b0;
        tick();
        nVectors++;
        if (release_prod !== 8'h04 || release_qty !== 4'd10 || change_units !== 12'd2 || change_valid !== 1'b1) begin
            nMiscompares++;
            $display("[TB] FAIL disc_dispense got rel=%0h qty=%0d chg=%0d cv=%0b want 04 10 2 1",
                     release_prod, release_qty, change_units, change_valid);
        end
        tick();
        nVectors++;
        if (warn_sig !== 8'h00) begin nMiscompares++; $display("[TB] FAIL disc_warn got %0h want 0", warn_sig); end
    endtask

    task automatic test_cancel_refund();
        key = 3'd1; key_valid = 1'b1; tick(); key_valid = 1'b0;
        confirm = 1'b1; tick(); confirm = 1'b0;
        nVectors++;
        if (pay_due !== 12'd4) begin nMiscompares++; $display("[TB] FAIL cancel_due got %0d want 4", pay_due); end
        coin = 2'b10; coin_valid = 1'b1; tick(); coin_valid = 1'b0;
        cancel = 1'b1; tick(); cancel = 1'b0;
        nVectors++;
        if (state_o !== 2'b00 || change_units !== 12'd4 || change_valid !== 1'b1 || release_prod !== 8'h00) begin
            nMiscompares++;
            $display("[TB] FAIL cancel_refund got st=%0h chg=%0d cv=%0b rel=%0h want 0 4 1 0",
                     state_o, change_units, change_valid, release_prod);
        end
        tick();
        nVectors++;
        if (change_valid !== 1'b0 || release_prod !== 8'h00) begin
            nMiscompares++; $display("[TB] FAIL cancel_after got cv=%0b rel=%0h want 0 0", change_valid, release_prod);
        end
    endtask

    task automatic test_low_stock();
        key = 3'd0; key_valid = 1'b1; tick(); key_valid = 1'b0;
        add_prod = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        add_prod = 1'b0;
        confirm = 1'b1; tick(); confirm = 1'b0;
        nVectors++;
        if (pay_due !== 12'd10) begin nMiscompares++; $display("[TB] FAIL low_due got %0d want 10", pay_due); end
        coin = 2'b11; coin_valid = 1'b1; tick(); coin_valid = 1'b0;
        tick();
        nVectors++;
        if (release_prod !== 8'h01 || release_qty !== 4'd11 || change_valid !== 1'b0 || change_units !== 12'd0) begin
            nMiscompares++;
            $display("[TB] FAIL low_dispense got rel=%0h qty=%0d cv=%0b chg=%0d want 01 11 0 0",
                     release_prod, release_qty, change_valid, change_units);
        end
        tick();
        nVectors++;
        if (warn_sig !== 8'h01) begin nMiscompares++; $display("[TB] FAIL low_warn got %0h want 01", warn_sig); end
        key_valid = 1'b1; tick(); key_valid = 1'b0;
        add_prod = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        add_prod = 1'b0;
        confirm = 1'b1; tick(); confirm = 1'b0;
        nVectors++;
        if (order_err !== 1'b1 || state_o !== 2'b01) begin
            nMiscompares++; $display("[TB] FAIL low_err got err=%0b st=%0h want 1 1", order_err, state_o);
        end
        tick();
        nVectors++;
        if (order_err !== 1'b0) begin nMiscompares++; $display("[TB] FAIL low_err_pulse got %0b want 0", order_err); end
        cancel = 1'b1; tick(); cancel = 1'b0;
        nVectors++;
        if (state_o !== 2'b00 || change_valid !== 1'b0) begin
            nMiscompares++; $display("[TB] FAIL low_cancel got st=%0h cv=%0b want 0 0", state_o, change_valid);
        end
        key = 3'd0; restock = 1'b1; tick(); restock = 1'b0;
        nVectors++;
        if (warn_sig !== 8'h00) begin nMiscompares++; $display("[TB] FAIL restock_warn got %0h want 0", warn_sig); end
    endtask

    task automatic test_cancel_coin_clr();
        key = 3'd5; key_valid = 1'b1; tick(); key_valid = 1'b0;
        confirm = 1'b1; tick(); confirm = 1'b0;
        coin = 2'b01; coin_valid = 1'b1; tick();
        coin = 2'b11; cancel = 1'b1; tick(); coin_valid = 1'b0; cancel = 1'b0;
        nVectors++;
        if (state_o !== 2'b00 || change_units !== 12'd2 || change_valid !== 1'b1) begin
            nMiscompares++;
            $display("[TB] FAIL cancel_coin got st=%0h chg=%0d cv=%0b want 0 2 1", state_o, change_units, change_valid);
        end
        key_valid = 1'b1; tick(); key_valid = 1'b0;
        confirm = 1'b1; tick(); confirm = 1'b0;
        nVectors++;
        if (state_o !== 2'b10 || pay_due !== 12'd5) begin
            nMiscompares++; $display("[TB] FAIL clr_pay got st=%0h due=%0d want 2 5", state_o, pay_due);
        end
        coin = 2'b00; coin_valid = 1'b1; tick(); coin_valid = 1'b0;
        CLR = 1'b1; tick(); CLR = 1'b0;
        nVectors++;
        if (state_o !== 2'b00 || change_valid !== 1'b0 || pay_due !== 12'd0 || release_prod !== 8'h00) begin
            nMiscompares++;
            $display("[TB] FAIL clr_abort got st=%0h cv=%0b due=%0d rel=%0h want 0 0 0 0",
                     state_o, change_valid, pay_due, release_prod);
        end
    endtask

    initial begin
        CLR = 1'b0; key = '0; key_valid = 1'b0; add_prod = 1'b0; confirm = 1'b0;
        coin = '0; coin_valid = 1'b0; cancel = 1'b0; restock = 1'b0;
        price_tbl = '0;
        price_tbl[0*8 +: 8] = 8'd1;
        price_tbl[1*8 +: 8] = 8'd4;
        price_tbl[2*8 +: 8] = 8'd2;
        price_tbl[5*8 +: 8] = 8'd5;
        price_tbl[6*8 +: 8] = 8'd3;
        #2;
        test_reset();
        test_single_buy();
        test_discount();
        test_cancel_refund();
        test_low_stock();
        test_cancel_coin_clr();
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
